// File: rtl/sample_mem_arbiter_pkg.sv
// Shared constants for the sample-memory arbiter: owner encoding, reader indices
// and default widths.
package sample_mem_arbiter_pkg;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 20;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_LD   = 3'd1,
    OWN_R0   = 3'd2,
    OWN_R1   = 3'd3,
    OWN_R2   = 3'd4
  } own_t;

  localparam logic [1:0] RD_MEAN = 2'd0;
  localparam logic [1:0] RD_CALC = 2'd1;
  localparam logic [1:0] RD_ERR  = 2'd2;

  function automatic own_t rd_own(input logic [1:0] idx);
    case (idx)
      RD_MEAN: return OWN_R0;
      RD_CALC: return OWN_R1;
      default: return OWN_R2;
    endcase
  endfunction

endpackage

// File: rtl/sample_mem_arbiter_rr_pick3.sv
// Three-way round-robin selector: first eligible reader starting after i_last.
module rr_pick3
  import sample_mem_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  input  logic [2:0] i_excl,
  output logic [1:0] o_winner,
  output logic       o_valid
);

  logic [2:0] w_eff;
  logic [2:0] w_pick;

  function automatic logic [2:0] pick_first(input logic [2:0] eff, input logic [1:0] a,
                                            input logic [1:0] b, input logic [1:0] c);
    if (eff[a]) begin
      return {1'b1, a};
    end else if (eff[b]) begin
      return {1'b1, b};
    end else if (eff[c]) begin
      return {1'b1, c};
    end else begin
      return 3'b000;
    end
  endfunction

  assign w_eff = i_req & ~i_excl;

  // Search order rotates so the reader after the last winner is tried first.
  always_comb begin
    w_pick = 3'b000;
    case (i_last)
      RD_MEAN: w_pick = pick_first(w_eff, RD_CALC, RD_ERR,  RD_MEAN);
      RD_CALC: w_pick = pick_first(w_eff, RD_ERR,  RD_MEAN, RD_CALC);
      default: w_pick = pick_first(w_eff, RD_MEAN, RD_CALC, RD_ERR);
    endcase
  end

  assign o_valid  = w_pick[2];
  assign o_winner = w_pick[1:0];

endmodule

// File: rtl/sample_mem_arbiter.sv
// Burst-granular owner of the single-port sample RAM: loader has fixed priority,
// readers rotate, and a hold limit forces handover while others wait.
module sample_mem_arbiter
  import sample_mem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  input  logic [2:0]    rd_req,
  input  logic [3*AW-1:0] rd_addr,
  output logic [2:0]    rd_gnt,
  output logic [2:0]    rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  own_t          r_own;
  logic [1:0]    r_last;
  logic [HW-1:0] r_hold;
  logic [2:0]    r_rd_valid;

  own_t       w_own_nxt;
  logic [1:0] w_last_nxt;
  logic       w_own_req;
  logic       w_own_rd;
  logic [1:0] w_own_idx;
  logic [2:0] w_own_mask;
  logic       w_others;
  logic       w_expire;
  logic       w_arb;
  logic [1:0] w_pick;
  logic       w_pick_valid;

  // Decode who owns the port and whether that owner is still requesting.
  always_comb begin
    w_own_req = 1'b0;
    w_own_rd  = 1'b0;
    w_own_idx = RD_MEAN;
    case (r_own)
      OWN_LD: w_own_req = ld_req;
      OWN_R0: begin w_own_rd = 1'b1; w_own_idx = RD_MEAN; w_own_req = rd_req[0]; end
      OWN_R1: begin w_own_rd = 1'b1; w_own_idx = RD_CALC; w_own_req = rd_req[1]; end
      OWN_R2: begin w_own_rd = 1'b1; w_own_idx = RD_ERR;  w_own_req = rd_req[2]; end
      default: w_own_req = 1'b0;
    endcase
  end

  assign w_own_mask = w_own_rd ? (3'b001 << w_own_idx) : 3'b000;
  assign w_others   = (r_own == OWN_LD) ? (|rd_req) : (ld_req | (|(rd_req & ~w_own_mask)));
  assign w_expire   = (r_own != OWN_NONE) && (r_hold == HW'(MAX_HOLD)) && w_others;
  assign w_arb      = (r_own == OWN_NONE) || !w_own_req || w_expire;

  rr_pick3 u_pick (
    .i_req    (rd_req),
    .i_last   (r_last),
    .i_excl   (w_expire ? w_own_mask : 3'b000),
    .o_winner (w_pick),
    .o_valid  (w_pick_valid)
  );

  // Next owner: keep unless released or expired; on expiry the owner sits out.
  always_comb begin
    w_own_nxt  = r_own;
    w_last_nxt = r_last;
    if (w_arb) begin
      if (ld_req && !(w_expire && (r_own == OWN_LD))) begin
        w_own_nxt = OWN_LD;
      end else if (w_pick_valid) begin
        w_own_nxt  = rd_own(w_pick);
        w_last_nxt = w_pick;
      end else begin
        w_own_nxt = OWN_NONE;
      end
    end else begin
      w_own_nxt = r_own;
    end
  end

  // Ownership, round-robin pointer, hold count and read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_own      <= OWN_NONE;
      r_last     <= RD_ERR;
      r_hold     <= {HW{1'b0}};
      r_rd_valid <= 3'b000;
    end else begin
      r_own      <= w_own_nxt;
      r_last     <= w_last_nxt;
      r_rd_valid <= rd_gnt & rd_req;
      if (w_own_nxt != r_own) begin
        r_hold <= (w_own_nxt == OWN_NONE) ? {HW{1'b0}} : HW'(1);
      end else if ((r_own != OWN_NONE) && (r_hold != HW'(MAX_HOLD))) begin
        r_hold <= r_hold + HW'(1);
      end else begin
        r_hold <= r_hold;
      end
    end
  end

  assign ld_gnt = (r_own == OWN_LD);
  assign rd_gnt = {r_own == OWN_R2, r_own == OWN_R1, r_own == OWN_R0};

  // Steer the owner's access onto the RAM port; idle port drives zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (w_own_req) begin
      if (r_own == OWN_LD) begin
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end else begin
        case (w_own_idx)
          RD_MEAN: mem_addr = rd_addr[0*AW +: AW];
          RD_CALC: mem_addr = rd_addr[1*AW +: AW];
          default: mem_addr = rd_addr[2*AW +: AW];
        endcase
      end
    end else begin
      mem_we = 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = (|r_rd_valid) ? mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_sample_mem_arbiter.sv
// Directed bench for sample_mem_arbiter with a 1-cycle synchronous RAM model.
module tb_sample_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_req;
  logic [7:0]  ld_addr;
  logic [19:0] ld_wdata;
  logic        ld_gnt;
  logic [2:0]  rd_req;
  logic [23:0] rd_addr;
  logic [2:0]  rd_gnt;
  logic [2:0]  rd_valid;
  logic [19:0] rd_data;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic [19:0] mem_rdata;

  logic [19:0] ram [256];
  logic [255:0] ram_wr;

  int n_checks;
  int n_fail;

  sample_mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations read back as 0x100 + address.
  always @(posedge clk) begin
    if (rst) begin
      ram_wr <= '0;
    end else if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : (20'h00100 + {12'd0, mem_addr});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_ldgnt"}, 32'(ld_gnt), 32'd0);
    check_val({tag, "_rdgnt"}, 32'(rd_gnt), 32'd0);
    check_val({tag, "_rdvalid"}, 32'(rd_valid), 32'd0);
    check_val({tag, "_rddata"}, 32'(rd_data), 32'd0);
    check_val({tag, "_we"}, 32'(mem_we), 32'd0);
    check_val({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check_val({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int grp;
    int pg;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; ld_req = 1'b0; ld_addr = 8'd0; ld_wdata = 20'd0;
    rd_req = 3'b000; rd_addr = 24'd0;
    cyc; cyc; #1;
    check_idle("reset");

    // All three readers contend: 16-cycle turns R0, R1, R2, then R0 again.
    rst = 1'b0; rd_req = 3'b111; rd_addr = {8'd30, 8'd20, 8'd10};
    for (int c = 0; c <= 48; c++) begin
      cyc; #1;
      grp = (c / 16) % 3;
      if ((c % 16 == 0) || (c % 16 == 15)) begin
        check_val("rr_gnt", 32'(rd_gnt), 32'(1 << grp));
        check_val("rr_addr", 32'(mem_addr), 32'(10 * (grp + 1)));
        if (c > 0) begin
          pg = ((c - 1) / 16) % 3;
          check_val("rr_valid", 32'(rd_valid), 32'(1 << pg));
          check_val("rr_data", 32'(rd_data), 32'(32'h100 + 10 * (pg + 1)));
        end else begin
          check_val("rr_valid0", 32'(rd_valid), 32'd0);
        end
      end
    end
    rd_req = 3'b000;
    cyc; cyc; #1;
    check_val("rr_release", 32'(rd_gnt), 32'd0);

    // Single loader write, then R1 reads it back.
    ld_req = 1'b1; ld_addr = 8'd5; ld_wdata = 20'h12345;
    cyc; #1;
    check_val("wr_gnt", 32'(ld_gnt), 32'd1);
    check_val("wr_we", 32'(mem_we), 32'd1);
    check_val("wr_addr", 32'(mem_addr), 32'd5);
    check_val("wr_wdata", 32'(mem_wdata), 32'h12345);
    cyc;
    ld_req = 1'b0; rd_req = 3'b010; rd_addr = {8'd0, 8'd5, 8'd0};
    #1;
    check_val("wr_once", 32'(mem_we), 32'd0);
    cyc; #1;
    check_val("rb_gnt", 32'(rd_gnt), 32'b010);
    check_val("rb_addr", 32'(mem_addr), 32'd5);
    check_val("rb_we", 32'(mem_we), 32'd0);
    check_val("rb_novalid", 32'(rd_valid), 32'd0);
    cyc;
    rd_req = 3'b000;
    #1;
    check_val("rb_valid", 32'(rd_valid), 32'b010);
    check_val("rb_data", 32'(rd_data), 32'h12345);
    cyc; cyc;

    // R2 owns the port; a loader request must wait for R2's release.
    rd_req = 3'b100; rd_addr = {8'd7, 8'd0, 8'd0};
    cyc; #1;
    check_val("r2_gnt", 32'(rd_gnt), 32'b100);
    ld_req = 1'b1; ld_addr = 8'd9; ld_wdata = 20'hABCDE;
    cyc; #1;
    check_val("nopre_rdgnt", 32'(rd_gnt), 32'b100);
    check_val("nopre_ldgnt", 32'(ld_gnt), 32'd0);
    check_val("nopre_addr", 32'(mem_addr), 32'd7);
    check_val("nopre_we", 32'(mem_we), 32'd0);
    cyc; #1;
    check_val("nopre_rdgnt2", 32'(rd_gnt), 32'b100);
    rd_req = 3'b000;
    #1;
    check_val("r2_rel_addr", 32'(mem_addr), 32'd0);
    check_val("r2_rel_we", 32'(mem_we), 32'd0);
    cyc; #1;
    check_val("ho_ldgnt", 32'(ld_gnt), 32'd1);
    check_val("ho_rdgnt", 32'(rd_gnt), 32'd0);
    check_val("ho_we", 32'(mem_we), 32'd1);
    check_val("ho_addr", 32'(mem_addr), 32'd9);
    ld_req = 1'b0;
    cyc; cyc; #1;
    check_val("ho_done", 32'(ld_gnt), 32'd0);

    // Loader and R0 together: loader first, then forced off after 16 cycles.
    ld_req = 1'b1; ld_addr = 8'd3; ld_wdata = 20'h00777;
    rd_req = 3'b001; rd_addr = {8'd0, 8'd0, 8'd12};
    cyc; #1;
    check_val("tie_ldgnt", 32'(ld_gnt), 32'd1);
    check_val("tie_rdgnt", 32'(rd_gnt), 32'd0);
    for (int k = 2; k <= 16; k++) cyc;
    #1;
    check_val("ldhold_last", 32'(ld_gnt), 32'd1);
    cyc; #1;
    check_val("ldexp_ldgnt", 32'(ld_gnt), 32'd0);
    check_val("ldexp_rdgnt", 32'(rd_gnt), 32'b001);
    check_val("ldexp_addr", 32'(mem_addr), 32'd12);
    ld_req = 1'b0; rd_req = 3'b000;
    cyc; cyc; #1;
    check_idle("ldexp_idle");

    // Uncontended three-cycle R0 burst.
    rd_req = 3'b001;
    cyc; #1;
    check_val("b3_gnt1", 32'(rd_gnt), 32'b001);
    check_val("b3_addr1", 32'(mem_addr), 32'd12);
    check_val("b3_val1", 32'(rd_valid), 32'd0);
    cyc; #1;
    check_val("b3_gnt2", 32'(rd_gnt), 32'b001);
    check_val("b3_val2", 32'(rd_valid), 32'b001);
    cyc;
    rd_req = 3'b000;
    #1;
    check_val("b3_gnt3", 32'(rd_gnt), 32'b001);
    check_val("b3_addr3", 32'(mem_addr), 32'd0);
    check_val("b3_we3", 32'(mem_we), 32'd0);
    check_val("b3_val3", 32'(rd_valid), 32'b001);
    cyc; #1;
    check_idle("b3_after");

    // Reset in the middle of a loader burst.
    ld_req = 1'b1; ld_addr = 8'd4; ld_wdata = 20'h55555;
    cyc; #1;
    check_val("rst_ld_gnt", 32'(ld_gnt), 32'd1);
    cyc;
    rst = 1'b1;
    cyc;
    rst = 1'b0; ld_req = 1'b0; rd_req = 3'b110; rd_addr = {8'd40, 8'd33, 8'd0};
    #1;
    check_idle("rst_mid");
    cyc; #1;
    check_val("rst_r1_gnt", 32'(rd_gnt), 32'b010);
    check_val("rst_r1_addr", 32'(mem_addr), 32'd33);
    rd_req = 3'b000;
    cyc; cyc;

    // Reset during a read drops the pending rd_valid and restores R0 priority.
    rd_req = 3'b001; rd_addr = {8'd40, 8'd33, 8'd12};
    cyc;
    rst = 1'b1;
    cyc;
    rst = 1'b0; rd_req = 3'b101;
    #1;
    check_val("rst_drop_valid", 32'(rd_valid), 32'd0);
    check_val("rst_drop_gnt", 32'(rd_gnt), 32'd0);
    cyc; #1;
    check_val("rst_last_ptr", 32'(rd_gnt), 32'b001);
    rd_req = 3'b000;
    cyc; cyc;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_mem_arbiter.md
# sample_mem_arbiter

Arbitrates the single-port sample memory of the linear-regression engine between the data loader (writer) and the three consumers: mean unit, coefficient-calc unit and error unit (readers). It sits between the sample RAM and those units. The top-level sequencer then no longer has to serialise memory access by hand, and the units can overlap. Ownership is granted per burst, with fixed loader priority, round-robin among readers and a hold limit that prevents starvation.

## Interface
- `AW`, default 8: memory address width.
- `DW`, default 20: sample word width (packed x,y).
- `MAX_HOLD`, default 16: maximum consecutive cycles one owner keeps the port while another requester waits.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `ld_req`  in  1  loader requests port; held for whole burst
- `ld_addr`  in  AW  loader write address
- `ld_wdata`  in  DW  loader write data
- `ld_gnt`  out  1  loader owns port
- `rd_req`  in  3  reader requests [0]=mean [1]=calc [2]=err
- `rd_addr`  in  3*AW  reader addresses, reader i at bits [i*AW +: AW]
- `rd_gnt`  out  3  one-hot reader ownership
- `rd_valid`  out  3  read data valid for reader i
- `rd_data`  out  DW  shared read data = `mem_rdata`
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  AW  RAM address
- `mem_wdata`  out  DW  RAM write data
- `mem_rdata`  in  DW  RAM read data, 1-cycle synchronous read

## Operation
- Owner register `own` takes one of NONE, LD, R0, R1, R2. `ld_gnt`/`rd_gnt` decode `own`; at most one grant bit is high.
- Arbitration point is any posedge where `own`=NONE, or the owner's req is low, or a hold expiry occurs.
- At an arbitration point:
  - If `ld_req` is high, LD wins.
  - Otherwise the first requesting reader starting at `(last+1) mod 3` wins, and `last` is updated to it.
  - If nothing is requesting, `own` becomes NONE.
- An active owner is never preempted by a higher-priority request, only by its own release or by hold expiry.
- Hold counter:
  - Counts cycles of the current ownership.
  - When it reaches `MAX_HOLD` and any other requester is high, that edge is an arbitration point with the current owner excluded.
  - The counter resets on every ownership change.
  - If no other requester is waiting, the owner keeps the port and the counter saturates.
- Access: each cycle the owner's req is high, `mem_addr` = owner address.
  - If owner = LD: `mem_we`=1 and `mem_wdata`=`ld_wdata`.
  - Otherwise `mem_we`=0.
  - When `own`=NONE, or the owner's req is low: `mem_we`=0 and `mem_addr`=0.
- Read return: `rd_valid[i]` is registered. It is 1 in the cycle after a cycle with `rd_gnt[i]` & `rd_req[i]`, with `rd_data` valid alongside it.
- Reset (any cycle, including mid-burst):
  - `own`=NONE, `last`=2 (so R0 has first reader priority), hold counter 0.
  - In-flight `rd_valid` is dropped.
  - All outputs 0 in the following cycle.

## Timing
- Request-to-grant: req high at edge t gives the grant visible in cycle t+1. The first access is in cycle t+1.
- Read latency: address in cycle c gives `rd_valid`/`rd_data` in cycle c+1.
- Handover has no dead cycle. If the owner drops req in cycle c while another req is high, the new grant is visible in c+1.
- Write: a single cycle with `mem_we` in the cycle the address is presented. No response is returned.
- Simultaneous requests:
  - LD beats all readers.
  - Readers resolve round-robin.
  - Grant order under continuous contention from all three readers is R0, R1, R2, R0.
- Hold expiry: the owner is granted for exactly `MAX_HOLD` access cycles. Its grant falls at the next edge, and the pointer moves past it.

## Structure
- Shared package holds:
  - owner encoding constants (`OWN_NONE`, `OWN_LD`, `OWN_R0..R2`)
  - reader index constants (`RD_MEAN`, `RD_CALC`, `RD_ERR`)
  - defaults for `AW`/`DW`
- Sub-module `rr_pick3`: combinational three-way round-robin selector with inputs req[2:0], last[1:0] and exclude mask, and outputs winner and valid. The owner register, hold counter and rd_valid pipeline stay in the top module.

## Test plan
- Reset then `rd_req`=3'b111 held: grants R0, then R1, then R2 after every 16-cycle hold. `rd_valid` follows each access by one cycle.
- `ld_req` high with addr 5, data 0x12345 for 1 cycle, then R1 reads addr 5: `mem_we` pulses once, and `rd_valid[1]` comes with `rd_data`=0x12345 two cycles after R1's request.
- R2 owns the port and `ld_req` rises: R2 is not preempted. LD is granted the cycle after R2 drops req.
- `ld_req` and `rd_req[0]` rise on the same edge: `ld_gnt`=1 next cycle and `rd_gnt`=0.
- R0 burst of 3 cycles with no contention: `rd_gnt` lasts exactly 3 cycles, then NONE, with `mem_addr`=0 and `mem_we`=0.
- `rst` asserted mid-LD burst: all outputs are 0 next cycle. After release with `rd_req`=3'b110, R1 wins.
